trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer that drives the machine CSR file's exception-write port and consumes its trap-vector and return-address outputs.
- Watches the retiring instruction for ecall, ebreak, illegal and mret, plus a level timer interrupt.
- On a trap it writes mepc/mcause in one cycle, then hands a redirect PC to fetch over a valid/ready handshake.
- Sits between the execute/retire stage, the CSR file and the PC/fetch unit.

Parameters:
- XLEN, 64, datapath width.
- ECALL_CAUSE, 11, mcause code for ecall from M-mode.
- TIMER_CAUSE, 7, interrupt code for the machine timer.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- retire_valid  in  1  instruction retiring this cycle.
- retire_pc  in  XLEN  PC of the retiring instruction.
- is_ecall  in  1  retiring instruction is ecall.
- is_ebreak  in  1  retiring instruction is ebreak.
- is_illegal  in  1  retiring instruction is illegal.
- is_mret  in  1  retiring instruction is mret.
- timer_irq  in  1  level timer interrupt request.
- mie  in  1  global interrupt enable.
- mtvec_val  in  XLEN  current mtvec from the CSR file.
- mepc_val  in  XLEN  current mepc from the CSR file.
- excep_wen  out  1  one-cycle write strobe to the CSR file.
- mepc_overri  out  XLEN  value to write into mepc.
- mcause_overri  out  XLEN  value to write into mcause.
- redir_valid  out  1  redirect request to fetch.
- redir_pc  out  XLEN  redirect target.
- redir_ready  in  1  fetch accepts the redirect.
- flush  out  1  kill younger pipeline instructions.
- busy  out  1  core must not retire while high.

Behaviour:
- Reset: rst low asynchronously forces state IDLE and clears irq_pend. All outputs reset to 0.
- States: IDLE, SAVE, VECTOR, RETURN.
- Events are sampled only in IDLE with busy low.
- IDLE priority, sampled on retire_valid=1:
  - is_illegal: cause 2, mepc=retire_pc.
  - else is_ebreak: cause 3, mepc=retire_pc.
  - else is_ecall: cause ECALL_CAUSE, mepc=retire_pc.
  - else is_mret: go to RETURN.
- Interrupts, when no synchronous event is taken that cycle:
  - Condition: irq_pend & mie.
  - Cause = 1<<(XLEN-1) | TIMER_CAUSE.
  - mepc = retire_pc+4 if retire_valid, else last_pc+4. last_pc is the most recent retired PC, reset 0.
  - The retiring instruction completes before the interrupt is taken.
- A synchronous trap or interrupt latches cause and mepc into registers, then moves to SAVE.
- irq_pend:
  - Set on any cycle timer_irq=1.
  - Cleared when an interrupt is taken.
  - Cleared on any cycle timer_irq=0, because the request is level-sensitive.
- SAVE, exactly 1 cycle:
  - excep_wen=1, with mepc_overri/mcause_overri = latched values.
  - flush=1, busy=1.
  - Next state VECTOR.
- VECTOR:
  - redir_valid=1, busy=1.
  - Base = {mtvec_val[XLEN-1:2],2'b00}.
  - If mtvec_val[1:0]==1 and the cause is an interrupt, redir_pc = base + 4*TIMER_CAUSE. Otherwise redir_pc = base.
  - redir_pc is registered on entry and stays stable while waiting.
  - Hold until redir_ready=1, then go to IDLE the next cycle.
- RETURN:
  - flush=1 on the first cycle only; busy=1 throughout.
  - redir_valid=1, redir_pc = mepc_val captured on entry.
  - No CSR write.
  - Go to IDLE on redir_ready.
- busy is combinational high in every non-IDLE state. retire_valid is ignored while busy.
- Multiple is_* flags set together are resolved by the priority above. mret combined with any exception is treated as the exception.
- The redirect may be accepted on its first cycle (redir_ready already high), giving total trap latency SAVE+VECTOR = 2 cycles.
- Reset asserted mid-operation aborts immediately: outputs 0, no partial excep_wen.
- mepc arithmetic is modulo 2^XLEN: retire_pc = 2^64-4 plus 4 wraps to 0.

Test Plan:
- ecall at retire_pc=0x8000_0010, mtvec=0x8000_0100, redir_ready=1 -> next cycle excep_wen=1, mepc_overri=0x8000_0010, mcause_overri=11. Following cycle redir_valid=1, redir_pc=0x8000_0100. IDLE after.
- is_illegal and is_ecall together at pc=0x8000_0020 -> mcause_overri=2, mepc_overri=0x8000_0020.
- timer_irq=1, mie=1, retire pc=0x8000_0040, mtvec=0x8000_0101 -> mcause_overri=0x8000_0000_0000_0007, mepc_overri=0x8000_0044, redir_pc=0x8000_011C. With mie=0: no trap, and irq_pend stays while timer_irq holds.
- mret with mepc_val=0x8000_0044, redir_ready low for 3 cycles -> excep_wen stays 0, redir_valid held 4 cycles with redir_pc stable at 0x8000_0044, busy high throughout.
- ecall at pc=0x8000_0050 while busy (VECTOR stalled) -> ignored; only the first trap is written.
- rst low during SAVE -> excep_wen, redir_valid and busy all 0 immediately. After release: IDLE, and a later ecall traps normally.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Redirect handshake between the trap sequencer (master) and the fetch unit (slave).
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic            ready;

  modport master (output valid, output pc, input ready);
  modport slave  (input valid, input pc, output ready);
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Watches retirement for ecall/ebreak/illegal/mret
// and a level timer interrupt, writes mepc/mcause to the CSR file for one cycle,
// then hands the trap vector or return address to fetch over valid/ready.
module trap_ctrl #(
  parameter int XLEN        = 64,
  parameter int ECALL_CAUSE = 11,
  parameter int TIMER_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic            is_ecall,
  input  logic            is_ebreak,
  input  logic            is_illegal,
  input  logic            is_mret,
  input  logic            timer_irq,
  input  logic            mie,
  input  logic [XLEN-1:0] mtvec_val,
  input  logic [XLEN-1:0] mepc_val,
  output logic            excep_wen,
  output logic [XLEN-1:0] mepc_overri,
  output logic [XLEN-1:0] mcause_overri,
  output logic            flush,
  output logic            busy,
  trap_ctrl_if.master     redir
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAVE   = 2'd1;
  localparam logic [1:0] S_VECTOR = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  // Interrupt bit in the MSB, timer code in the low bits.
  localparam logic [XLEN-1:0] IRQ_CAUSE  = (XLEN'(1) << (XLEN - 1)) | XLEN'(TIMER_CAUSE);
  // Vectored-mode slot offset for the timer interrupt.
  localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(4 * TIMER_CAUSE);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            irq_pend;
  logic            ret_first;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] redir_pc_q;

  logic            idle;
  logic            accept;
  logic            exc_hit;
  logic            take_exc;
  logic            take_mret;
  logic            take_irq;
  logic            take_trap;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] irq_mepc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_mepc;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_target;

  // Events are only looked at while idle; retirement is ignored while busy.
  assign idle      = (state == S_IDLE);
  assign accept    = idle & retire_valid;
  assign exc_hit   = is_illegal | is_ebreak | is_ecall;
  assign take_exc  = accept & exc_hit;
  // An mret that also carries an exception flag is handled as the exception.
  assign take_mret = accept & ~exc_hit & is_mret;
  // The interrupt only wins when nothing synchronous is taken this cycle.
  assign take_irq  = idle & irq_pend & mie & ~take_exc & ~take_mret;
  assign take_trap = take_exc | take_irq;

  // Synchronous cause, priority illegal > ebreak > ecall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    exc_cause = XLEN'(ECALL_CAUSE);
    if (is_illegal)     exc_cause = XLEN'(2);
    else if (is_ebreak) exc_cause = XLEN'(3);
  end

  // The retiring instruction completes first, so the interrupt returns past it.
  // The add wraps modulo 2^XLEN.
  assign irq_mepc   = (retire_valid ? retire_pc : last_pc) + XLEN'(4);
  assign trap_cause = take_exc ? exc_cause : IRQ_CAUSE;
  assign trap_mepc  = take_exc ? retire_pc : irq_mepc;

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  assign vec_base   = {mtvec_val[XLEN-1:2], 2'b00};
  assign vec_target = ((mtvec_val[1:0] == 2'b01) && cause_q[XLEN-1])
                      ? vec_base + VEC_OFFSET : vec_base;

  // Next-state sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_trap)      state_nxt = S_SAVE;
        else if (take_mret) state_nxt = S_RETURN;
      end
      S_SAVE:   state_nxt = S_VECTOR;
      S_VECTOR: if (redir.ready) state_nxt = S_IDLE;
      S_RETURN: if (redir.ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Level-sensitive pending flag: follows timer_irq, dropped when the interrupt is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_pend <= 1'b0;
    else      irq_pend <= timer_irq & ~take_irq;
  end

  // Most recent accepted retirement PC, used when an interrupt arrives with no retirement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_pc <= '0;
    else if (accept) last_pc <= retire_pc;
  end

  // Cause and return address latched on trap entry, presented during SAVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_q <= '0;
      mepc_q  <= '0;
    end else if (take_trap) begin
      cause_q <= trap_cause;
      mepc_q  <= trap_mepc;
    end
  end

  // Redirect target captured on entry to VECTOR or RETURN so it holds while fetch stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 redir_pc_q <= '0;
    else if (state == S_SAVE) redir_pc_q <= vec_target;
    else if (take_mret)       redir_pc_q <= mepc_val;
  end

  // Marks the first RETURN cycle, the only one that flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ret_first <= 1'b0;
    else      ret_first <= take_mret;
  end

  // Outputs decode straight from registers, so reset clears them immediately.
  assign excep_wen     = (state == S_SAVE);
  assign mepc_overri   = mepc_q;
  assign mcause_overri = cause_q;
  assign flush         = (state == S_SAVE) | ((state == S_RETURN) & ret_first);
  assign busy          = ~idle;
  assign redir.valid   = (state == S_VECTOR) | (state == S_RETURN);
  assign redir.pc      = redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a trap-level model.
module tb_trap_ctrl;

  localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  logic        clk;
  logic        rst;
  logic        retire_valid;
  logic [63:0] retire_pc;
  logic        is_ecall, is_ebreak, is_illegal, is_mret;
  logic        timer_irq;
  logic        mie;
  logic [63:0] mtvec_val;
  logic [63:0] mepc_val;
  logic        excep_wen;
  logic [63:0] mepc_overri;
  logic [63:0] mcause_overri;
  logic        flush;
  logic        busy;

  trap_ctrl_if #(.XLEN(64)) rif ();

  trap_ctrl #(.XLEN(64), .ECALL_CAUSE(11), .TIMER_CAUSE(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .is_ecall      (is_ecall),
    .is_ebreak     (is_ebreak),
    .is_illegal    (is_illegal),
    .is_mret       (is_mret),
    .timer_irq     (timer_irq),
    .mie           (mie),
    .mtvec_val     (mtvec_val),
    .mepc_val      (mepc_val),
    .excep_wen     (excep_wen),
    .mepc_overri   (mepc_overri),
    .mcause_overri (mcause_overri),
    .flush         (flush),
    .busy          (busy),
    .redir         (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] m_last_pc;

  typedef struct {
    logic [63:0] pc;
    logic        ill, ebr, ecl, mret;
    logic [63:0] mtvec;
    logic [63:0] exp_cause;
    logic [63:0] exp_mepc;
    logic [63:0] exp_target;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_retire();
    retire_valid = 1'b0;
    is_ecall     = 1'b0;
    is_ebreak    = 1'b0;
    is_illegal   = 1'b0;
    is_mret      = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_b({tag, " busy"}, busy, 1'b0);
    check_b({tag, " redir_valid"}, rif.valid, 1'b0);
    check_b({tag, " excep_wen"}, excep_wen, 1'b0);
  endtask

  // One synchronous trap from idle with fetch ready at once: SAVE then VECTOR then idle.
  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    retire_valid = 1'b1;
    retire_pc    = v.pc;
    is_illegal   = v.ill;
    is_ebreak    = v.ebr;
    is_ecall     = v.ecl;
    is_mret      = v.mret;
    mtvec_val    = v.mtvec;
    rif.ready    = 1'b1;
    step();
    check_b({t, " save excep_wen"}, excep_wen, 1'b1);
    check({t, " save mcause"}, mcause_overri, v.exp_cause);
    check({t, " save mepc"}, mepc_overri, v.exp_mepc);
    check_b({t, " save flush"}, flush, 1'b1);
    check_b({t, " save busy"}, busy, 1'b1);
    clear_retire();
    step();
    check_b({t, " vec redir_valid"}, rif.valid, 1'b1);
    check({t, " vec redir_pc"}, rif.pc, v.exp_target);
    check_b({t, " vec excep_wen"}, excep_wen, 1'b0);
    check_b({t, " vec flush"}, flush, 1'b0);
    step();
    check_idle({t, " done"});
    rif.ready = 1'b0;
  endtask

  // Randomized trap transaction; expectations come from the trap rules, not the FSM.
  task automatic rand_txn(input int n);
    logic        t_pre, m, rv, ill, ebr, ecl, mr;
    logic [63:0] pc, tv, mv, exp_cause, exp_mepc, exp_tgt;
    bit          sync_t, ret_t, irq_t;
    int          d;
    string       t;
    t      = $sformatf("rnd%0d", n);
    t_pre  = 1'($urandom_range(0, 1));
    m      = 1'($urandom_range(0, 1));
    rv     = ($urandom_range(0, 3) != 0);
    ill    = ($urandom_range(0, 5) == 0);
    ebr    = ($urandom_range(0, 5) == 0);
    ecl    = ($urandom_range(0, 4) == 0);
    mr     = ($urandom_range(0, 3) == 0);
    pc     = {$urandom, $urandom} & ~64'h3;
    if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tv     = {$urandom, $urandom};
    mv     = {$urandom, $urandom};
    d      = $urandom_range(0, 3);

    // Pre-cycle: arm (or not) the pending interrupt with interrupts masked.
    clear_retire();
    mie       = 1'b0;
    timer_irq = t_pre;
    rif.ready = 1'b0;
    step();
    check_b({t, " pre busy"}, busy, 1'b0);

    sync_t    = rv && (ill || ebr || ecl);
    ret_t     = rv && !sync_t && mr;
    irq_t     = !sync_t && !ret_t && t_pre && m;
    exp_cause = ill ? 64'd2 : (ebr ? 64'd3 : 64'd11);
    exp_mepc  = pc;
    if (irq_t) begin
      exp_cause = IRQ_CAUSE;
      exp_mepc  = (rv ? pc : m_last_pc) + 64'd4;
    end
    exp_tgt = tv & ~64'h3;
    if (irq_t && tv[1:0] == 2'b01) exp_tgt = (tv & ~64'h3) + 64'd28;
    if (ret_t) exp_tgt = mv;
    if (rv) m_last_pc = pc;

    retire_valid = rv;
    retire_pc    = pc;
    is_illegal   = ill;
    is_ebreak    = ebr;
    is_ecall     = ecl;
    is_mret      = mr;
    mie          = m;
    timer_irq    = 1'b0;
    mtvec_val    = tv;
    mepc_val     = mv;
    step();

    if (sync_t || irq_t) begin
      check_b({t, " save excep_wen"}, excep_wen, 1'b1);
      check({t, " save mcause"}, mcause_overri, exp_cause);
      check({t, " save mepc"}, mepc_overri, exp_mepc);
      // Stray retirement while busy must be ignored.
      retire_valid = 1'b1;
      is_ecall     = 1'b1;
      retire_pc    = {$urandom, $urandom};
      step();
    end
    if (sync_t || irq_t || ret_t) begin
      for (int c = 0; c <= d; c++) begin
        check_b({t, " redir_valid"}, rif.valid, 1'b1);
        check({t, " redir_pc"}, rif.pc, exp_tgt);
        check_b({t, " flush"}, flush, ret_t && (c == 0));
        check_b({t, " wait excep_wen"}, excep_wen, 1'b0);
        mtvec_val    = {$urandom, $urandom};
        mepc_val     = {$urandom, $urandom};
        retire_valid = 1'(($urandom_range(0, 1)));
        is_ecall     = 1'b1;
        retire_pc    = {$urandom, $urandom};
        rif.ready    = (c == d);
        step();
      end
    end
    clear_retire();
    rif.ready = 1'b0;
    check_idle({t, " end"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{64'h8000_0010, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'd11, 64'h8000_0010, 64'h8000_0100};
    vecs[1] = '{64'h8000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'd2,  64'h8000_0020, 64'h8000_0100};
    vecs[2] = '{64'h8000_0030, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0101, 64'd3,  64'h8000_0030, 64'h8000_0100};
    vecs[3] = '{64'h8000_0034, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0000_1003, 64'd3,  64'h8000_0034, 64'h0000_1000};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_2002, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_2000};
    vecs[5] = '{64'h8000_0048, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0200, 64'd11, 64'h8000_0048, 64'h8000_0200};

    rst       = 1'b0;
    clear_retire();
    retire_pc = '0;
    timer_irq = 1'b0;
    mie       = 1'b0;
    mtvec_val = '0;
    mepc_val  = '0;
    rif.ready = 1'b0;
    #1;
    check_b("reset excep_wen", excep_wen, 1'b0);
    check("reset mepc_overri", mepc_overri, 64'd0);
    check("reset mcause_overri", mcause_overri, 64'd0);
    check_b("reset redir_valid", rif.valid, 1'b0);
    check("reset redir_pc", rif.pc, 64'd0);
    check_b("reset flush", flush, 1'b0);
    check_b("reset busy", busy, 1'b0);
    #7 rst = 1'b1;
    step();
    check_idle("post reset");

    // Directed synchronous traps.
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // Timer interrupt taken alongside a retiring instruction, vectored mtvec.
    timer_irq = 1'b1;
    mie       = 1'b1;
    step();
    check_b("irq arm busy", busy, 1'b0);
    retire_valid = 1'b1;
    retire_pc    = 64'h8000_0040;
    mtvec_val    = 64'h8000_0101;
    rif.ready    = 1'b1;
    step();
    check_b("irq save excep_wen", excep_wen, 1'b1);
    check("irq save mcause", mcause_overri, IRQ_CAUSE);
    check("irq save mepc", mepc_overri, 64'h8000_0044);
    clear_retire();
    timer_irq = 1'b0;
    step();
    check_b("irq vec redir_valid", rif.valid, 1'b1);
    check("irq vec redir_pc", rif.pc, 64'h8000_011C);
    step();
    check_idle("irq done");

    // Masked interrupt: no trap, pending survives while timer_irq holds.
    timer_irq    = 1'b1;
    mie          = 1'b0;
    retire_valid = 1'b1;
    retire_pc    = 64'h8000_0060;
    step();
    check_b("masked busy 1", busy, 1'b0);
    step();
    check_b("masked busy 2", busy, 1'b0);
    clear_retire();
    step();
    check_b("masked busy 3", busy, 1'b0);
    mie = 1'b1;
    step();
    check_b("unmask excep_wen", excep_wen, 1'b1);
    check("unmask mcause", mcause_overri, IRQ_CAUSE);
    check("unmask mepc from last_pc", mepc_overri, 64'h8000_0064);
    timer_irq = 1'b0;
    step();
    check("unmask redir_pc", rif.pc, 64'h8000_011C);
    step();
    check_idle("unmask done");

    // Pending clears as soon as the level request drops.
    timer_irq = 1'b1;
    mie       = 1'b0;
    step();
    timer_irq = 1'b0;
    step();
    mie = 1'b1;
    step();
    check_b("irq dropped busy 1", busy, 1'b0);
    step();
    check_b("irq dropped busy 2", busy, 1'b0);

    // Interrupt return address wraps modulo 2^64.
    timer_irq = 1'b1;
    mie       = 1'b0;
    step();
    mie          = 1'b1;
    timer_irq    = 1'b0;
    retire_valid = 1'b1;
    retire_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("wrap mepc", mepc_overri, 64'd0);
    check("wrap mcause", mcause_overri, IRQ_CAUSE);
    clear_retire();
    step();
    step();
    check_idle("wrap done");
    mie = 1'b0;

    // mret with fetch stalled for three cycles.
    mepc_val     = 64'h8000_0044;
    rif.ready    = 1'b0;
    retire_valid = 1'b1;
    is_mret      = 1'b1;
    retire_pc    = 64'h8000_0080;
    step();
    check_b("mret c1 redir_valid", rif.valid, 1'b1);
    check("mret c1 redir_pc", rif.pc, 64'h8000_0044);
    check_b("mret c1 flush", flush, 1'b1);
    check_b("mret c1 busy", busy, 1'b1);
    check_b("mret c1 excep_wen", excep_wen, 1'b0);
    clear_retire();
    mepc_val = 64'hDEAD_BEEF_0000_0000;
    for (int i = 2; i <= 4; i++) begin
      step();
      check_b($sformatf("mret c%0d redir_valid", i), rif.valid, 1'b1);
      check($sformatf("mret c%0d redir_pc", i), rif.pc, 64'h8000_0044);
      check_b($sformatf("mret c%0d flush", i), flush, 1'b0);
      check_b($sformatf("mret c%0d busy", i), busy, 1'b1);
      check_b($sformatf("mret c%0d excep_wen", i), excep_wen, 1'b0);
    end
    rif.ready = 1'b1;
    step();
    check_idle("mret done");
    rif.ready = 1'b0;

    // Second ecall while busy is ignored.
    retire_valid = 1'b1;
    is_ecall     = 1'b1;
    retire_pc    = 64'h8000_0070;
    mtvec_val    = 64'h8000_0300;
    step();
    check("busy-ecall first mepc", mepc_overri, 64'h8000_0070);
    retire_pc = 64'h8000_0050;
    step();
    check("busy-ecall redir_pc", rif.pc, 64'h8000_0300);
    for (int i = 0; i < 2; i++) begin
      step();
      check_b("busy-ecall stall excep_wen", excep_wen, 1'b0);
      check_b("busy-ecall stall redir_valid", rif.valid, 1'b1);
    end
    clear_retire();
    rif.ready = 1'b1;
    step();
    check_idle("busy-ecall done");
    check("busy-ecall mepc kept", mepc_overri, 64'h8000_0070);
    rif.ready = 1'b0;
    step();
    check_b("busy-ecall no second trap", excep_wen, 1'b0);

    // Reset in the middle of SAVE aborts immediately.
    retire_valid = 1'b1;
    is_ecall     = 1'b1;
    retire_pc    = 64'h8000_0090;
    step();
    check_b("pre-abort excep_wen", excep_wen, 1'b1);
    clear_retire();
    rst = 1'b0;
    #1;
    check_b("abort excep_wen", excep_wen, 1'b0);
    check_b("abort redir_valid", rif.valid, 1'b0);
    check_b("abort busy", busy, 1'b0);
    check_b("abort flush", flush, 1'b0);
    #2 rst = 1'b1;
    step();
    check_idle("after abort");
    apply_vec(vecs[0], 0);

    // Randomized transactions from a clean reset.
    rst = 1'b0;
    #2 rst = 1'b1;
    m_last_pc = 64'd0;
    for (int n = 0; n < 200; n++) rand_txn(n);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
